// File: rtl/voting_tally_ctrl_pkg.sv
// Shared types and width helpers for the ballot collector / tally controller.
package voting_tally_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bits needed to index n items, never less than one so single-item cases stay legal.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Width of a per-candidate tally: it must hold every voter voting for one candidate.
  function automatic int tally_cnt_w(input int n_voters);
    return clog2_min1(n_voters + 1);
  endfunction

endpackage

// File: rtl/voting_tally_ctrl_if.sv
// Voter-side ballot handshake: per-voter valid and ballot, one-hot ready grant back.
interface voting_tally_ctrl_if #(
  parameter int N_VOTERS = 4,
  parameter int CAND_W   = 2
);
  logic [N_VOTERS-1:0]        vote_valid;
  logic [N_VOTERS*CAND_W-1:0] vote_data;
  logic [N_VOTERS-1:0]        vote_ready;

  modport master (output vote_valid, output vote_data, input vote_ready);
  modport slave  (input vote_valid, input vote_data, output vote_ready);
endinterface

// File: rtl/voting_tally_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  // Walk the requesters starting at the pointer and wrap; the first hit wins.
  always_comb begin
    int   w_idx;
    logic w_found;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = (int'(i_ptr) + off) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voting_tally_ctrl.sv
// Ballot collector: round-robin accepts one ballot per voter, tallies per candidate,
// then scans the tallies one candidate per cycle to report winner, count and tie.
module voting_tally_ctrl
  import voting_tally_ctrl_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int N_CAND   = 4,
  parameter int CAND_W   = 2,
  parameter int CNT_W    = tally_cnt_w(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  voting_tally_ctrl_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [CAND_W-1:0]   winner,
  output logic [CNT_W-1:0]    winner_cnt,
  output logic                tie,
  output logic [CNT_W-1:0]    abstain_cnt
);

  localparam int PTR_W  = clog2_min1(N_VOTERS);
  localparam int SCAN_W = clog2_min1(N_CAND);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(N_VOTERS - 1);
  localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(N_CAND - 1);

  state_t              r_state;
  logic [N_VOTERS-1:0] r_voted;
  logic [CNT_W-1:0]    r_cnt [N_CAND];
  logic [CNT_W-1:0]    r_abstain;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [SCAN_W-1:0]   r_scan_idx;
  logic [CNT_W-1:0]    r_max;
  logic [CAND_W-1:0]   r_win;
  logic                r_tie_run;
  logic                r_done;
  logic [CAND_W-1:0]   r_winner;
  logic [CNT_W-1:0]    r_winner_cnt;
  logic                r_tie;
  logic [CNT_W-1:0]    r_abstain_out;

  logic [N_VOTERS-1:0] w_req;
  logic [N_VOTERS-1:0] w_gnt;
  logic [N_VOTERS-1:0] w_ready;
  logic                w_accept;
  logic [PTR_W-1:0]    w_gidx;
  logic [PTR_W-1:0]    w_ptr_nx;
  logic [CAND_W-1:0]   w_ballot;
  logic                w_ballot_ok;
  logic                w_full;
  logic [CNT_W-1:0]    w_scan_cnt;
  logic [CNT_W-1:0]    w_max_nx;
  logic [CAND_W-1:0]   w_win_nx;
  logic                w_tie_nx;

  // Voters that already voted this round drop out of arbitration.
  assign w_req = bus.vote_valid & ~r_voted;

  rr_arbiter #(
    .N     (N_VOTERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  assign w_ready        = (r_state == COLLECT) ? w_gnt : '0;
  assign bus.vote_ready = w_ready;
  assign w_accept       = |w_ready;
  assign w_full         = &(r_voted | w_ready);

  // Encode the one-hot grant back to a voter index.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      if (w_gnt[i]) w_gidx = PTR_W'(i);
    end
  end

  assign w_ptr_nx    = (w_gidx == LAST_PTR) ? '0 : w_gidx + 1'b1;
  assign w_ballot    = bus.vote_data[w_gidx*CAND_W +: CAND_W];
  assign w_ballot_ok = (int'(w_ballot) < N_CAND);

  assign w_scan_cnt = r_cnt[r_scan_idx];

  // Running max for the current scan step; strictly greater replaces, equal flags a tie.
  always_comb begin
    w_max_nx = r_max;
    w_win_nx = r_win;
    w_tie_nx = r_tie_run;
    if (r_scan_idx == '0) begin
      w_max_nx = w_scan_cnt;
      w_win_nx = '0;
      w_tie_nx = 1'b0;
    end else if (w_scan_cnt > r_max) begin
      w_max_nx = w_scan_cnt;
      w_win_nx = CAND_W'(r_scan_idx);
      w_tie_nx = 1'b0;
    end else if (w_scan_cnt == r_max) begin
      w_tie_nx = 1'b1;
    end
  end

  // Round FSM with tallies, scan state and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_voted       <= '0;
      r_abstain     <= '0;
      r_rr_ptr      <= '0;
      r_scan_idx    <= '0;
      r_max         <= '0;
      r_win         <= '0;
      r_tie_run     <= 1'b0;
      r_done        <= 1'b0;
      r_winner      <= '0;
      r_winner_cnt  <= '0;
      r_tie         <= 1'b0;
      r_abstain_out <= '0;
      for (int c = 0; c < N_CAND; c++) r_cnt[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_voted       <= '0;
            r_abstain     <= '0;
            r_winner      <= '0;
            r_winner_cnt  <= '0;
            r_tie         <= 1'b0;
            r_abstain_out <= '0;
            for (int c = 0; c < N_CAND; c++) r_cnt[c] <= '0;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_voted  <= r_voted | w_ready;
            r_rr_ptr <= w_ptr_nx;
            if (w_ballot_ok) r_cnt[w_ballot] <= r_cnt[w_ballot] + 1'b1;
            else             r_abstain       <= r_abstain + 1'b1;
          end
          // A ballot accepted alongside close still counts before scanning.
          if (w_full || close) begin
            r_scan_idx <= '0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_max     <= w_max_nx;
          r_win     <= w_win_nx;
          r_tie_run <= w_tie_nx;
          if (r_scan_idx == LAST_IDX) begin
            r_winner      <= w_win_nx;
            r_winner_cnt  <= w_max_nx;
            r_tie         <= w_tie_nx;
            r_abstain_out <= r_abstain;
            r_done        <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign winner      = r_winner;
  assign winner_cnt  = r_winner_cnt;
  assign tie         = r_tie;
  assign abstain_cnt = r_abstain_out;

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Scoreboard bench: two controllers (4 and 3 candidates) share one voter stimulus.
module tb_voting_tally_ctrl;

  localparam int NV    = 4;
  localparam int CW    = 2;
  localparam int CNT_W = $clog2(NV + 1);

  typedef struct {
    int winner;
    int cnt;
    int tie;
    int abst;
    int cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic close;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  voting_tally_ctrl_if #(.N_VOTERS(NV), .CAND_W(CW)) if_a ();
  voting_tally_ctrl_if #(.N_VOTERS(NV), .CAND_W(CW)) if_b ();
  assign if_b.vote_valid = if_a.vote_valid;
  assign if_b.vote_data  = if_a.vote_data;

  logic             busy_a, done_a, tie_a, busy_b, done_b, tie_b;
  logic [CW-1:0]    win_a, win_b;
  logic [CNT_W-1:0] wcnt_a, abs_a, wcnt_b, abs_b;

  voting_tally_ctrl #(.N_VOTERS(NV), .N_CAND(4), .CAND_W(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .close(close), .bus(if_a.slave),
    .busy(busy_a), .done(done_a), .winner(win_a), .winner_cnt(wcnt_a),
    .tie(tie_a), .abstain_cnt(abs_a)
  );

  voting_tally_ctrl #(.N_VOTERS(NV), .N_CAND(3), .CAND_W(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .close(close), .bus(if_b.slave),
    .busy(busy_b), .done(done_b), .winner(win_b), .winner_cnt(wcnt_b),
    .tie(tie_b), .abstain_cnt(abs_b)
  );

  logic [NV-1:0] q_rdy[$];
  res_t          q_a[$];
  res_t          q_b[$];
  int            n_checks = 0;
  int            n_err    = 0;
  int            m_ptr    = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void cmp_res(input string tag, input res_t r, input logic [31:0] w,
                                  input logic [31:0] c, input logic [31:0] t, input logic [31:0] a);
    check({tag, "_done_cycle"}, cyc, r.cyc);
    check({tag, "_winner"}, w, r.winner);
    check({tag, "_winner_cnt"}, c, r.cnt);
    check({tag, "_tie"}, t, r.tie);
    check({tag, "_abstain"}, a, r.abst);
  endfunction

  // Reference result computed directly from the accepted ballots (-1 = no ballot).
  function automatic res_t ref_result(input int nc, input int ballots[NV], input int ecyc);
    res_t r;
    int   tally[4];
    int   mx;
    int   nmax;
    for (int c = 0; c < 4; c++) tally[c] = 0;
    r.abst = 0;
    for (int v = 0; v < NV; v++) begin
      if (ballots[v] >= 0) begin
        if (ballots[v] < nc) tally[ballots[v]]++;
        else r.abst++;
      end
    end
    mx = 0;
    for (int c = 0; c < nc; c++) if (tally[c] > mx) mx = tally[c];
    r.winner = -1;
    nmax = 0;
    for (int c = 0; c < nc; c++) begin
      if (tally[c] == mx) begin
        nmax++;
        if (r.winner < 0) r.winner = c;
      end
    end
    r.cnt = mx;
    r.tie = (nmax >= 2) ? 1 : 0;
    r.cyc = ecyc + nc + 1;
    return r;
  endfunction

  function automatic int model_grant(input logic [NV-1:0] vv, input bit voted[NV], input int ptr);
    int idx;
    for (int off = 0; off < NV; off++) begin
      idx = (ptr + off) % NV;
      if (vv[idx] && !voted[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: ready compared every queued cycle, results popped on each done pulse.
  always @(negedge clk) begin
    logic [NV-1:0] e;
    res_t          r;
    if (q_rdy.size() != 0) begin
      e = q_rdy.pop_front();
      check("ready_a", if_a.vote_ready, e);
      check("ready_b", if_b.vote_ready, e);
    end
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL done_a: pulse at cycle %0d, expected none", cyc);
      end else begin
        r = q_a.pop_front();
        cmp_res("a", r, win_a, wcnt_a, tie_a, abs_a);
      end
    end
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL done_b: pulse at cycle %0d, expected none", cyc);
      end else begin
        r = q_b.pop_front();
        cmp_res("b", r, win_b, wcnt_b, tie_b, abs_b);
      end
    end
  end

  function automatic void check_cleared(input string tag);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_winner_a"}, win_a, 0);
    check({tag, "_wcnt_a"}, wcnt_a, 0);
    check({tag, "_tie_a"}, tie_a, 0);
    check({tag, "_abst_a"}, abs_a, 0);
    check({tag, "_ready_a"}, if_a.vote_ready, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_winner_b"}, win_b, 0);
    check({tag, "_ready_b"}, if_b.vote_ready, 0);
  endfunction

  // One round, entered at posedge+1 with both controllers idle.
  // mode 0/1: fixed ballots, all valid; mode 2: only v2, close after 3 cycles; 3: random.
  task automatic run_round(input int mode);
    int            ballots[NV];
    bit            voted[NV];
    logic [NV-1:0] vv;
    logic [NV*CW-1:0] dd;
    logic          cl;
    int            g;
    int            ecyc;
    bit            all_v;
    res_t          ra;
    res_t          rb;
    for (int v = 0; v < NV; v++) begin ballots[v] = -1; voted[v] = 0; end
    ecyc = 0;
    start = 1'b1;
    if_a.vote_valid = NV'($urandom);
    if_a.vote_data  = (NV*CW)'($urandom);
    q_rdy.push_back('0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      case (mode)
        0: begin vv = 4'b1111; dd = {2'd3, 2'd1, 2'd1, 2'd2}; cl = 1'b0; end
        1: begin vv = 4'b1111; dd = {2'd2, 2'd0, 2'd2, 2'd0}; cl = 1'b0; end
        2: begin vv = 4'b0100; dd = (NV*CW)'($urandom); dd[5:4] = 2'd2; cl = (k == 2); end
        default: begin
          vv = NV'($urandom);
          dd = (NV*CW)'($urandom);
          cl = ($urandom_range(0, 9) == 0) || (k == 30);
        end
      endcase
      if_a.vote_valid = vv;
      if_a.vote_data  = dd;
      close = cl;
      g = model_grant(vv, voted, m_ptr);
      q_rdy.push_back((g >= 0) ? NV'(1 << g) : '0);
      if (g >= 0) begin
        ballots[g] = int'(dd[g*CW +: CW]);
        voted[g]   = 1;
        m_ptr      = (g + 1) % NV;
      end
      all_v = 1;
      for (int v = 0; v < NV; v++) if (!voted[v]) all_v = 0;
      if (all_v || cl) begin
        ecyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    ra = ref_result(4, ballots, ecyc);
    rb = ref_result(3, ballots, ecyc);
    q_a.push_back(ra);
    q_b.push_back(rb);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      close = 1'b0;
      start = (j <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      if_a.vote_valid = NV'($urandom);
      if_a.vote_data  = (NV*CW)'($urandom);
      q_rdy.push_back('0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    if_a.vote_valid = '0;
    check("idle_busy_a", busy_a, 0);
    check("idle_busy_b", busy_b, 0);
    check("held_winner_a", win_a, ra.winner);
    check("held_wcnt_a", wcnt_a, ra.cnt);
    check("held_winner_b", win_b, rb.winner);
    check("held_abst_b", abs_b, rb.abst);
  endtask

  // Asynchronous reset pulse in the middle of a clock phase.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    q_rdy.delete();
    q_a.delete();
    q_b.delete();
    #1;
    check_cleared("async_rst");
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    m_ptr = 0;
    if_a.vote_valid = '0;
  endtask

  task automatic reset_mid_round();
    bit voted[NV];
    int g;
    for (int v = 0; v < NV; v++) voted[v] = 0;
    start = 1'b1;
    if_a.vote_valid = '0;
    q_rdy.push_back('0);
    @(posedge clk); #1;
    start = 1'b0;
    if_a.vote_valid = 4'b1111;
    if_a.vote_data  = (NV*CW)'($urandom);
    g = model_grant(4'b1111, voted, m_ptr);
    q_rdy.push_back(NV'(1 << g));
    @(posedge clk); #1;
    async_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    close = 1'b0;
    if_a.vote_valid = '0;
    if_a.vote_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_cleared("reset");
    run_round(0);
    run_round(1);
    run_round(2);
    async_reset();
    reset_mid_round();
    run_round(0);
    for (int i = 0; i < 25; i++) run_round(3);
    repeat (3) @(posedge clk);
    #1;
    check("pending_done_a", q_a.size(), 0);
    check("pending_done_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
